// File: rtl/isp_reg_arbiter.sv
// Two-port round-robin arbiter for the ISP register bus (m0 = AHB bridge, m1 = AE/AWB engine).
// Optional read timeout: define ISP_ARB_RD_TIMEOUT_EN (adds the RD_TIMEOUT parameter).
module isp_reg_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32
`ifdef ISP_ARB_RD_TIMEOUT_EN
    ,
    parameter int unsigned RD_TIMEOUT = 64
`endif
) (
    input  logic              AHB_HCLK,
    input  logic              AHB_HRESETn,

    input  logic              m0_req,
    input  logic              m0_wr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_wr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              isp_reg_wr_en,
    output logic              isp_reg_rd_en,
    output logic [ADDR_W-1:0] isp_reg_addr,
    output logic [DATA_W-1:0] isp_reg_wr_data,
    input  logic [DATA_W-1:0] isp_reg_rd_data,
    input  logic              isp_rd_rdy,

    output logic              arb_busy,
    output logic              arb_owner
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RDWAIT,
        ST_DONE
    } state_t;

    state_t              r_state;
    logic                r_last_served;
    logic                r_owner;
    logic                r_busy;
    logic                r_m0_gnt;
    logic                r_m1_gnt;
    logic                r_m0_done;
    logic                r_m1_done;
    logic                r_m0_err;
    logic                r_m1_err;
    logic [DATA_W-1:0]   r_m0_rdata;
    logic [DATA_W-1:0]   r_m1_rdata;
    logic                r_wr_en;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_any_req;
    logic                w_pick;
    logic                w_win_wr;
    logic [ADDR_W-1:0]   w_win_addr;
    logic [DATA_W-1:0]   w_win_wdata;
    logic                w_timeout;
    logic                w_fin;
    logic                w_fin_rd;
    logic                w_fin_err;
    logic [DATA_W-1:0]   w_fin_data;

    // On a tie the port that was not served last wins.
    assign w_any_req   = m0_req | m1_req;
    assign w_pick      = m1_req & (~m0_req | ~r_last_served);
    assign w_win_wr    = w_pick ? m1_wr    : m0_wr;
    assign w_win_addr  = w_pick ? m1_addr  : m0_addr;
    assign w_win_wdata = w_pick ? m1_wdata : m0_wdata;

`ifdef ISP_ARB_RD_TIMEOUT_EN
    localparam int unsigned CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

    logic [CNT_W-1:0] r_rd_cnt;

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            r_rd_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            r_rd_cnt <= '0;
        end else if (r_state == ST_RDWAIT && !w_timeout) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
    end

    assign w_timeout = (r_rd_cnt == CNT_W'(RD_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Completion decode; rd_rdy is ignored while rd_en is still high since it may be stale.
    always_comb begin
        w_fin      = 1'b0;
        w_fin_rd   = 1'b0;
        w_fin_err  = 1'b0;
        w_fin_data = isp_reg_rd_data;
        case (r_state)
            ST_WRITE: begin
                w_fin = 1'b1;
            end
            ST_RDWAIT: begin
                if (!r_rd_en && isp_rd_rdy) begin
                    w_fin    = 1'b1;
                    w_fin_rd = 1'b1;
                end else if (w_timeout) begin
                    w_fin      = 1'b1;
                    w_fin_rd   = 1'b1;
                    w_fin_err  = 1'b1;
                    w_fin_data = '1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            r_state       <= ST_IDLE;
            r_last_served <= 1'b1;
            r_owner       <= 1'b0;
            r_busy        <= 1'b0;
            r_m0_gnt      <= 1'b0;
            r_m1_gnt      <= 1'b0;
            r_m0_done     <= 1'b0;
            r_m1_done     <= 1'b0;
            r_m0_err      <= 1'b0;
            r_m1_err      <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
            r_wr_en       <= 1'b0;
            r_rd_en       <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
        end else begin
            r_m0_gnt  <= 1'b0;
            r_m1_gnt  <= 1'b0;
            r_m0_done <= 1'b0;
            r_m1_done <= 1'b0;
            r_m0_err  <= 1'b0;
            r_m1_err  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner       <= w_pick;
                        r_last_served <= w_pick;
                        r_m0_gnt      <= ~w_pick;
                        r_m1_gnt      <= w_pick;
                        r_addr        <= w_win_addr;
                        r_wdata       <= w_win_wdata;
                        r_busy        <= 1'b1;
                        if (w_win_wr) begin
                            r_wr_en <= 1'b1;
                            r_state <= ST_WRITE;
                        end else begin
                            r_rd_en <= 1'b1;
                            r_state <= ST_RDWAIT;
                        end
                    end
                end
                ST_WRITE, ST_RDWAIT: begin
                    if (w_fin) begin
                        r_state <= ST_DONE;
                        if (r_owner) begin
                            r_m1_done <= 1'b1;
                            r_m1_err  <= w_fin_err;
                            if (w_fin_rd) r_m1_rdata <= w_fin_data;
                        end else begin
                            r_m0_done <= 1'b1;
                            r_m0_err  <= w_fin_err;
                            if (w_fin_rd) r_m0_rdata <= w_fin_data;
                        end
                    end
                end
                ST_DONE: begin
                    // No sampling here, so a requester still holding req this cycle is not re-accepted.
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt          = r_m0_gnt;
    assign m1_gnt          = r_m1_gnt;
    assign m0_done         = r_m0_done;
    assign m1_done         = r_m1_done;
    assign m0_err          = r_m0_err;
    assign m1_err          = r_m1_err;
    assign m0_rdata        = r_m0_rdata;
    assign m1_rdata        = r_m1_rdata;
    assign isp_reg_wr_en   = r_wr_en;
    assign isp_reg_rd_en   = r_rd_en;
    assign isp_reg_addr    = r_addr;
    assign isp_reg_wr_data = r_wdata;
    assign arb_busy        = r_busy;
    assign arb_owner       = r_owner;

endmodule

// File: doc/isp_reg_arbiter.md
Name: isp_reg_arbiter

Overview:
- Shares the single ISP register access bus between two requesters.
  - Port 0: the AHB bridge (CPU register path).
  - Port 1: the hardware auto-exposure/auto-white-balance engine.
- Serialises one transaction at a time, using round-robin arbitration on ties.
- Drives the downstream enable/address/data strobes and returns read data with a done/error handshake.
- Sits between the AHB bridge and the ISP register file (CCM/GAMMA/AEAWB/histogram).

Parameters:
- ADDR_W, 16, register address width.
- DATA_W, 32, register data width.
- RD_TIMEOUT, 64, cycles in RDWAIT before a read is abandoned; only used with the optional feature.

Ports:
- AHB_HCLK  in  1  clock.
- AHB_HRESETn  in  1  asynchronous active-low reset.
- m0_req / m1_req  in  1  request; held high, fields stable, until the matching done.
- m0_wr / m1_wr  in  1  1 = write, 0 = read.
- m0_addr / m1_addr  in  ADDR_W  register address.
- m0_wdata / m1_wdata  in  DATA_W  write data.
- m0_gnt / m1_gnt  out  1  one-cycle pulse: request accepted.
- m0_done / m1_done  out  1  one-cycle pulse: transaction complete.
- m0_err / m1_err  out  1  valid with done; 1 = read timeout.
- m0_rdata / m1_rdata  out  DATA_W  read data, valid with done; holds until the next done to that port.
- isp_reg_wr_en  out  1  one-cycle write strobe.
- isp_reg_rd_en  out  1  one-cycle read strobe.
- isp_reg_addr  out  ADDR_W  target address, held until the next grant.
- isp_reg_wr_data  out  DATA_W  write data, held until the next grant.
- isp_reg_rd_data  in  DATA_W  read data from the register file.
- isp_rd_rdy  in  1  read data valid, level.
- arb_busy  out  1  high whenever the state is not IDLE.
- arb_owner  out  1  owner of the current or last transaction (0 = m0, 1 = m1).

Behaviour:
- Clocking and reset:
  - One clock, AHB_HCLK.
  - Reset is asynchronous and active-low on AHB_HRESETn.
  - On reset, every output is 0, m*_rdata is 0, state = IDLE, and last_served = 1, so m0 wins the first tie.
  - Reset mid-transaction aborts it; no done is issued.
- All outputs are registered.
- State machine: IDLE -> (WRITE | RDWAIT) -> DONE -> IDLE.
- IDLE:
  - Requests are sampled at each clock edge.
  - If only one request is high, that requester wins.
  - If both are high, the requester not equal to last_served wins.
  - On accept (edge E0), the following are registered:
    - gnt = 1 for one cycle.
    - isp_reg_addr and isp_reg_wr_data from the winner.
    - arb_owner = winner, last_served = winner.
    - wr_en = wr, or rd_en = ~wr.
    - Next state = WRITE if wr, else RDWAIT.
- WRITE: lasts one cycle while wr_en is high, then goes to DONE.
- RDWAIT:
  - isp_rd_rdy is ignored during the first RDWAIT cycle (the rd_en cycle), because it may be stale.
  - From the second RDWAIT edge on, when isp_rd_rdy = 1, isp_reg_rd_data is captured into the owner's rdata and the state goes to DONE.
- DONE:
  - The owner's done = 1 for exactly one cycle, with err, then IDLE.
  - The requester drops req in the done cycle.
  - The arbiter does not sample in DONE, so the same request cannot be re-accepted.
- Latency:
  - Write done is high in cycle E0+2.
  - Read done is high at the earliest in cycle E0+3.
  - The next accept is at the earliest at the edge ending cycle E0+3 (write).
- Fairness: with continuous requests from both ports, grants alternate m0, m1, m0, ...
- A request arriving during a busy transaction waits; it is never dropped.
- Requests with fields changing while req is high and not yet granted are allowed. The values sampled at the accepting edge are used.
- The strobes isp_reg_wr_en and isp_reg_rd_en are never high simultaneously, and each is never high for more than one cycle.

Optional Feature:
- Macro: ISP_ARB_RD_TIMEOUT_EN.
- Defined:
  - A counter runs in RDWAIT.
  - If it reaches RD_TIMEOUT-1 with no isp_rd_rdy, the state goes to DONE with err = 1 and rdata = 32'hFFFFFFFF.
  - The counter clears on every accept.
  - If rdy and timeout occur in the same cycle, rdy wins (err = 0).
- Undefined: RDWAIT waits indefinitely, err is tied to 0, and the counter logic is absent.

Test Plan:
- m0 write addr 16'h0204, data 32'h0000_1234 -> m0_gnt and isp_reg_wr_en high in cycle E0+1 with addr 0x0204 and data 0x1234; m0_done high in cycle E0+2 with err = 0.
- m1 read addr 16'h0460, isp_rd_rdy held high, rd_data 32'hA5A5_0001 -> rd_rdy ignored in the rd_en cycle; m1_done in cycle E0+3 with m1_rdata = 0xA5A50001.
- m0 and m1 request simultaneously out of reset, both held for 4 transactions -> grant order m0, m1, m0, m1; no cycle with both strobes high.
- Reset asserted in RDWAIT -> all outputs 0 immediately; no done; after release, a fresh m0 read completes normally.
- With ISP_ARB_RD_TIMEOUT_EN and RD_TIMEOUT = 64, read with rdy held low -> m0_done with err = 1 and rdata = 32'hFFFFFFFF 64 cycles after rd_en. Without the macro -> no done after 1000 cycles, and arb_busy stays 1.
- m1 requests during an m0 write -> m1 accepted at the first IDLE edge after m0_done; m1 request never lost.
